// File: rtl/exu_sb_pkg.sv
// Shared definitions for the execute-issue scoreboard.
// Holds the register index width, the default sizing and the counter-vector type.
package exu_sb_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int NREG_DEF         = 32;
  localparam int CNT_W_DEF        = 2;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int INFL_W_DEF       = $clog2(MAX_INFLIGHT_DEF + 1);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // All per-register pending-write counts for the default configuration.
  // Element 0 (x0) always reads as zero.
  typedef logic [NREG_DEF-1:0][CNT_W_DEF-1:0] cnt_vec_t;

endpackage

// File: rtl/exu_issue_scoreboard_if.sv
// Decode -> execute handshake plus the retire port of the issue scoreboard.
//
// Handshake semantics: the decode side raises idu_valid with rs1/rs2/rd and
// qualifiers stable, and keeps them until idu_valid && idu_ready is seen at a
// clock edge (flush may withdraw the offer). idu_ready and exu_valid never
// depend on idu_valid's history, only on the current inputs and state; a
// transfer happens in exactly the cycles where idu_valid && idu_ready is
// high, and in those cycles exu_valid && exu_ready is high as well.
// wb_valid is a single-cycle pulse per retiring instruction.
interface exu_issue_scoreboard_if;
  import exu_sb_pkg::*;

  logic     idu_valid;
  logic     idu_ready;
  reg_idx_t rs1;
  reg_idx_t rs2;
  reg_idx_t rd;
  logic     use_rs1;
  logic     use_rs2;
  logic     rd_wen;
  logic     exu_valid;
  logic     exu_ready;
  logic     flush;
  logic     wb_valid;
  reg_idx_t wb_rd;
  logic     wb_wen;

  // Environment side: decode, execute unit and writeback.
  modport master (
    output idu_valid, rs1, rs2, rd, use_rs1, use_rs2, rd_wen,
    output exu_ready, flush, wb_valid, wb_rd, wb_wen,
    input  idu_ready, exu_valid
  );

  // Scoreboard side.
  modport slave (
    input  idu_valid, rs1, rs2, rd, use_rs1, use_rs2, rd_wen,
    input  exu_ready, flush, wb_valid, wb_rd, wb_wen,
    output idu_ready, exu_valid
  );

endinterface

// File: rtl/exu_sb_counter.sv
// One pending-write counter for a single architectural register.
// Saturates at both ends; a simultaneous inc and dec leaves it unchanged.
module exu_sb_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         at_max
);

  assign zero   = (count == '0);
  assign at_max = (count == '1);

  // Count issued-but-unretired writes; ignore steps that would wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + W'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/exu_issue_scoreboard.sv
// Issue scoreboard between decode and the execute unit.
// Tracks outstanding writes per register and in-flight instructions, and holds
// the decode handshake on RAW hazards, counter saturation or a full window.
// Optional feature macro: EXU_SB_BYPASS_EN -- hazard checks see this cycle's
// retire, so a consumer can issue in the same cycle as its producer's retire.
module exu_issue_scoreboard
  import exu_sb_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                                   clock,
  input  logic                                   reset,
  exu_issue_scoreboard_if.slave                  sb_bus,
  output logic [31:0]                            stall_cycles,
  output logic [NREG-1:0][CNT_W-1:0]             reg_cnt,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight
);

  localparam int                INFL_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_arr [NREG];
  logic [NREG-1:1]  zero_v;
  logic [NREG-1:1]  max_v;
  logic [NREG-1:1]  retire_hit;
  logic [NREG-1:1]  issue_hit;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  at_lim;

  logic retire_wr;
  logic raw;
  logic sat;
  logic full;
  logic go;
  logic issue;

  // x0 is never tracked and always reads as idle.
  assign cnt_arr[0] = '0;

  assign retire_wr = sb_bus.wb_valid && sb_bus.wb_wen && (sb_bus.wb_rd != '0);

  // Decode which register the retiring write targets.
  always_comb begin
    retire_hit = '0;
    for (int r = 1; r < NREG; r++) begin
      retire_hit[r] = retire_wr && (sb_bus.wb_rd == REG_IDX_W'(r));
    end
  end

  // Decode which register the issuing write targets.
  always_comb begin
    issue_hit = '0;
    for (int r = 1; r < NREG; r++) begin
      issue_hit[r] = issue && sb_bus.rd_wen && (sb_bus.rd == REG_IDX_W'(r));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    exu_sb_counter #(.W(CNT_W)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .inc    (issue_hit[g]),
      .dec    (retire_hit[g]),
      .count  (cnt_arr[g]),
      .zero   (zero_v[g]),
      .at_max (max_v[g])
    );
  end

  // Per-register hazard view: registered counts, optionally minus this cycle's retire.
  always_comb begin
    busy   = '0;
    at_lim = '0;
    for (int r = 1; r < NREG; r++) begin
`ifdef EXU_SB_BYPASS_EN
      busy[r]   = !zero_v[r] && !(retire_hit[r] && (cnt_arr[r] == CNT_W'(1)));
      at_lim[r] = max_v[r] && !retire_hit[r];
`else
      busy[r]   = !zero_v[r];
      at_lim[r] = max_v[r];
`endif
    end
  end

  // Issue gating from the offered instruction's operands and the window occupancy.
  always_comb begin
    raw = (sb_bus.use_rs1 && (sb_bus.rs1 != '0) && busy[sb_bus.rs1]) ||
          (sb_bus.use_rs2 && (sb_bus.rs2 != '0) && busy[sb_bus.rs2]);
    sat = sb_bus.rd_wen && (sb_bus.rd != '0) && at_lim[sb_bus.rd];
`ifdef EXU_SB_BYPASS_EN
    full = (inflight == INFL_MAX) && !sb_bus.wb_valid;
`else
    full = (inflight == INFL_MAX);
`endif
    go = !reset && !sb_bus.flush && !raw && !sat && !full;
  end

  assign sb_bus.exu_valid = sb_bus.idu_valid && go;
  assign sb_bus.idu_ready = sb_bus.exu_ready && go;
  assign issue            = sb_bus.idu_valid && sb_bus.idu_ready;

  // Expose the count vector for observation; x0 slot is constant zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      reg_cnt[r] = cnt_arr[r];
    end
  end

  // Instructions issued but not yet retired; simultaneous issue and retire cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue, sb_bus.wb_valid})
        2'b10:   if (inflight != INFL_MAX) inflight <= inflight + INFL_W'(1);
        2'b01:   if (inflight != '0)       inflight <= inflight - INFL_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Saturating count of cycles where decode offers but is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (sb_bus.idu_valid && !sb_bus.idu_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

`ifndef SYNTHESIS
  // Flag retire pulses that have no outstanding instruction or write behind them.
  always_ff @(posedge clock) begin
    if (!reset && sb_bus.wb_valid) begin
      assert (inflight != '0)
        else $error("exu_issue_scoreboard: retire with nothing in flight");
      if (retire_wr) begin
        assert (cnt_arr[sb_bus.wb_rd] != '0)
          else $error("exu_issue_scoreboard: retire of x%0d with zero pending writes", sb_bus.wb_rd);
      end
    end
  end
`endif

endmodule

// File: tb/tb_exu_issue_scoreboard.sv
// Self-checking bench for exu_issue_scoreboard: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_exu_issue_scoreboard;
  import exu_sb_pkg::*;

  localparam int MAXC = (1 << CNT_W_DEF) - 1;
  localparam int MAXI = MAX_INFLIGHT_DEF;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exu_issue_scoreboard_if bus ();
  logic [31:0]           stall_cycles;
  cnt_vec_t              reg_cnt;
  logic [INFL_W_DEF-1:0] inflight;

  exu_issue_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .sb_bus       (bus),
    .stall_cycles (stall_cycles),
    .reg_cnt      (reg_cnt),
    .inflight     (inflight)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [5:0] exp_q [$];        // {wen, rd} of every issued, unretired instruction
  int         mcnt [NREG_DEF];  // outstanding writes per register
  longint     mstall;
  int         errors = 0;
  int         checks = 0;
  logic       last_dut_issue;
  logic       last_dut_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_cnt(input logic [4:0] r);
    int c;
    c = mcnt[r];
`ifdef EXU_SB_BYPASS_EN
    if (bus.wb_valid && bus.wb_wen && bus.wb_rd == r && r != 5'd0) c = c - 1;
`endif
    return c;
  endfunction

  function automatic logic model_go();
    int   infl;
    logic raw, sat, full;
    infl = exp_q.size();
`ifdef EXU_SB_BYPASS_EN
    if (bus.wb_valid) infl = infl - 1;
`endif
    raw  = (bus.use_rs1 && bus.rs1 != 5'd0 && eff_cnt(bus.rs1) != 0) ||
           (bus.use_rs2 && bus.rs2 != 5'd0 && eff_cnt(bus.rs2) != 0);
    sat  = bus.rd_wen && bus.rd != 5'd0 && eff_cnt(bus.rd) == MAXC;
    full = (infl == MAXI);
    return !reset && !bus.flush && !raw && !sat && !full;
  endfunction

  function automatic cnt_vec_t model_vec();
    cnt_vec_t v;
    for (int r = 0; r < NREG_DEF; r++) v[r] = CNT_W_DEF'(mcnt[r]);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic offer(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic wen);
    bus.idu_valid = v;
    bus.rs1 = s1; bus.use_rs1 = u1;
    bus.rs2 = s2; bus.use_rs2 = u2;
    bus.rd  = d;  bus.rd_wen  = wen;
  endtask

  task automatic set_retire(input logic en);
    if (en && exp_q.size() > 0) begin
      bus.wb_valid = 1'b1;
      {bus.wb_wen, bus.wb_rd} = exp_q[0];
    end else begin
      bus.wb_valid = 1'b0;
      bus.wb_wen   = 1'b0;
      bus.wb_rd    = 5'd0;
    end
  endtask

  // One clock: check combinational outputs, advance model at the edge, check state.
  task automatic step();
    logic       go, exp_ready, exp_valid;
    logic [5:0] rec;
    #1;
    go        = model_go();
    exp_ready = bus.exu_ready && go;
    exp_valid = bus.idu_valid && go;
    check("exu_valid", 64'(bus.exu_valid), 64'(exp_valid));
    check("idu_ready", 64'(bus.idu_ready), 64'(exp_ready));
    last_dut_issue = bus.idu_valid && bus.idu_ready;
    last_dut_valid = bus.exu_valid;
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      for (int r = 0; r < NREG_DEF; r++) mcnt[r] = 0;
      mstall = 0;
    end else begin
      if (bus.wb_valid && exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        if (rec[5] && rec[4:0] != 5'd0) mcnt[rec[4:0]] = mcnt[rec[4:0]] - 1;
      end
      if (bus.idu_valid && exp_ready) begin
        exp_q.push_back({bus.rd_wen, bus.rd});
        if (bus.rd_wen && bus.rd != 5'd0) mcnt[bus.rd] = mcnt[bus.rd] + 1;
      end
      if (bus.idu_valid && !exp_ready && mstall != 64'hFFFF_FFFF) mstall = mstall + 1;
    end
    #1;
    check("stall_cycles", 64'(stall_cycles), 64'(mstall));
    check("inflight", 64'(inflight), 64'(exp_q.size()));
    check("reg_cnt", 64'(reg_cnt), 64'(model_vec()));
    @(negedge clock);
  endtask

  task automatic idle();
    offer(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      set_retire(1'b1);
      step();
    end
    set_retire(1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic pending;

  initial begin
    for (int r = 0; r < NREG_DEF; r++) mcnt[r] = 0;
    mstall = 0;
    reset = 1'b1;
    bus.exu_ready = 1'b1;
    bus.flush     = 1'b0;
    set_retire(1'b0);
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    @(negedge clock);
    step();
    check("reset_exu_valid", 64'(last_dut_valid), 64'd0);
    step();
    reset = 1'b0;
    idle();
    step();
    check("reset_stall", 64'(stall_cycles), 64'd0);
    check("reset_inflight", 64'(inflight), 64'd0);

    // Back-to-back independent writes.
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    step();
    check("b2b_issue0", 64'(last_dut_issue), 64'd1);
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    step();
    check("b2b_issue1", 64'(last_dut_issue), 64'd1);
    check("b2b_cnt5", 64'(reg_cnt[5]), 64'd1);
    check("b2b_cnt6", 64'(reg_cnt[6]), 64'd1);
    drain();

    // RAW on x3.
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    step();
    offer(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("raw_held", 64'(last_dut_issue), 64'd0);
    end
    check("raw_stall3", 64'(stall_cycles), 64'd3);
    set_retire(1'b1);
    step();
    set_retire(1'b0);
`ifdef EXU_SB_BYPASS_EN
    check("raw_bypass_issue", 64'(last_dut_issue), 64'd1);
`else
    check("raw_wb_cycle_held", 64'(last_dut_issue), 64'd0);
    step();
    check("raw_issue_next", 64'(last_dut_issue), 64'd1);
`endif
    drain();

    // x0 never stalls or counts.
    for (int k = 0; k < 6; k++) begin
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      set_retire(k > 0);
      step();
      check("x0_issue", 64'(last_dut_issue), 64'd1);
    end
    drain();
    check("x0_cnt_zero", 64'(reg_cnt), 64'd0);

    // Saturation on x7: fourth write blocks.
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      step();
      check("sat_issue", 64'(last_dut_issue), (k < 3) ? 64'd1 : 64'd0);
    end
    drain();

    // Full window: fifth independent instruction blocks.
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + k), 1'b1);
      step();
      check("full_issue", 64'(last_dut_issue), (k < 4) ? 64'd1 : 64'd0);
    end
    drain();

    // Flush squashes only its own cycle.
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    bus.flush = 1'b1;
    step();
    check("flush_valid", 64'(last_dut_valid), 64'd0);
    check("flush_cnt8", 64'(reg_cnt[8]), 64'd0);
    bus.flush = 1'b0;
    step();
    check("flush_then_issue", 64'(last_dut_issue), 64'd1);
    drain();

    // Simultaneous issue and retire on x9.
    offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    step();
    set_retire(1'b1);
    step();
    set_retire(1'b0);
    check("simul_issue", 64'(last_dut_issue), 64'd1);
    check("simul_cnt9", 64'(reg_cnt[9]), 64'd1);
    check("simul_inflight", 64'(inflight), 64'd1);
    drain();

    // Random traffic with a mid-stream reset.
    pending = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        reset = 1'b1;
        pending = 1'b0;
        idle();
        set_retire(1'b0);
        step();
        reset = 1'b0;
        check("rst_mid_stall", 64'(stall_cycles), 64'd0);
        check("rst_mid_cnt", 64'(reg_cnt), 64'd0);
        check("rst_mid_inflight", 64'(inflight), 64'd0);
      end
      if (!pending && $urandom_range(0, 3) != 0) begin
        offer(1'b1, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        pending = 1'b1;
      end
      bus.idu_valid = pending;
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.exu_ready = ($urandom_range(0, 3) != 0);
      set_retire($urandom_range(0, 2) == 0);
      step();
      if (last_dut_issue) pending = 1'b0;
      else if (bus.flush && $urandom_range(0, 1) == 1) pending = 1'b0;
    end
    bus.flush = 1'b0;
    bus.exu_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
